// File: rtl/res_station.sv
// Single-entry reservation station for one ALU/shift functional unit.
// Holds one issued op, snoops the CDB to fill pending operands, and frees
// itself when its own tag's result is broadcast on the CDB.

package res_station_pkg;

  typedef logic [31:0] word32_t;

  // Producer identities on the CDB; NO_VAL marks an idle bus / ready operand.
  typedef enum logic [2:0] {
    NO_VAL = 3'd0,
    ALU_1  = 3'd1,
    ALU_2  = 3'd2,
    ALU_3  = 3'd3,
    LSU_1  = 3'd4,
    LSU_2  = 3'd5,
    MUL_1  = 3'd6,
    MUL_2  = 3'd7
  } rs_tag_t;

  typedef enum logic [3:0] {
    ADDI = 4'd0,
    ADDR = 4'd1,
    SUBR = 4'd2,
    ANDR = 4'd3,
    ORR  = 4'd4,
    XORR = 4'd5,
    ANDI = 4'd6,
    ORI  = 4'd7,
    XORI = 4'd8,
    SLTR = 4'd9,
    SLTI = 4'd10,
    LUI  = 4'd11
  } alu_op_t;

  typedef enum logic [2:0] {
    SLLI = 3'd0,
    SRLI = 3'd1,
    SRAI = 3'd2,
    SLLR = 3'd3,
    SRLR = 3'd4,
    SRAR = 3'd5
  } shift_op_t;

  typedef struct packed {
    rs_tag_t tag;
    word32_t val;
  } cdb_t;

endpackage

module res_station
  import res_station_pkg::*;
#(
  parameter rs_tag_t TAG = ALU_1
) (
  input  logic      clk_i,
  input  logic      reset_i,
  input  cdb_t      cdb_i,
  input  logic      write_i,
  input  alu_op_t   alu_opcode_i,
  input  shift_op_t shift_opcode_i,
  input  rs_tag_t   tag1_i,
  input  rs_tag_t   tag2_i,
  input  word32_t   value1_i,
  input  word32_t   value2_i,
  output logic      fu_ready_o,
  output alu_op_t   fu_alu_oper_o,
  output shift_op_t fu_shift_oper_o,
  output word32_t   fu_rs1_val_o,
  output word32_t   fu_rs2_val_o,
  output logic      busy_o
);

  // Entry state; operand 1 lives at index 0, operand 2 at index 1.
  logic      r_busy;
  alu_op_t   r_op_alu;
  shift_op_t r_op_shift;
  rs_tag_t   r_tag [2];
  word32_t   r_val [2];

  // Next-state values and issue-side operand views.
  logic      w_busy_next;
  alu_op_t   w_op_alu_next;
  shift_op_t w_op_shift_next;
  rs_tag_t   w_tag_next [2];
  word32_t   w_val_next [2];
  rs_tag_t   w_tag_in   [2];
  word32_t   w_val_in   [2];
  logic      w_fwd_in   [2];
  logic      w_snoop    [2];

  logic      w_cdb_valid;
  logic      w_own_bcast;
  logic      w_accept;

  assign w_tag_in[0] = tag1_i;
  assign w_tag_in[1] = tag2_i;
  assign w_val_in[0] = value1_i;
  assign w_val_in[1] = value2_i;

  // An idle bus (NO_VAL) must never look like a match, even against a
  // register that itself holds NO_VAL.
  assign w_cdb_valid = (cdb_i.tag != NO_VAL);
  assign w_own_bcast = w_cdb_valid && (cdb_i.tag == TAG);

  // A new op may land in the same cycle the current one's result is on the
  // CDB, so the entry turns over without a bubble.
  assign w_accept = write_i && (!r_busy || w_own_bcast);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      // Operand whose producer is broadcasting right now is forwarded at issue.
      assign w_fwd_in[gi] = (w_tag_in[gi] != NO_VAL) && (w_tag_in[gi] == cdb_i.tag);
      // Pending operand captured while the entry waits.
      assign w_snoop[gi]  = r_busy && (r_tag[gi] != NO_VAL) && (r_tag[gi] == cdb_i.tag);

      assign w_tag_next[gi] = w_accept ? (w_fwd_in[gi] ? NO_VAL : w_tag_in[gi])
                                       : (w_snoop[gi]  ? NO_VAL : r_tag[gi]);
      assign w_val_next[gi] = w_accept ? (w_fwd_in[gi] ? cdb_i.val : w_val_in[gi])
                                       : (w_snoop[gi]  ? cdb_i.val : r_val[gi]);
    end
  endgenerate

  // Occupancy and opcode next-state: load on accept, release on own broadcast.
  always_comb begin
    w_busy_next     = r_busy;
    w_op_alu_next   = r_op_alu;
    w_op_shift_next = r_op_shift;
    if (w_accept) begin
      w_busy_next     = 1'b1;
      w_op_alu_next   = alu_opcode_i;
      w_op_shift_next = shift_opcode_i;
    end else if (r_busy && w_own_bcast) begin
      w_busy_next     = 1'b0;
    end
  end

  // State register; reset overrides everything, including an op in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_busy     <= 1'b0;
      r_op_alu   <= ADDI;
      r_op_shift <= SLLI;
      for (int i = 0; i < 2; i++) begin
        r_tag[i] <= NO_VAL;
        r_val[i] <= '0;
      end
    end else begin
      r_busy     <= w_busy_next;
      r_op_alu   <= w_op_alu_next;
      r_op_shift <= w_op_shift_next;
      for (int i = 0; i < 2; i++) begin
        r_tag[i] <= w_tag_next[i];
        r_val[i] <= w_val_next[i];
      end
    end
  end

  assign busy_o          = r_busy;
  assign fu_ready_o      = r_busy && (r_tag[0] == NO_VAL) && (r_tag[1] == NO_VAL);
  assign fu_alu_oper_o   = r_op_alu;
  assign fu_shift_oper_o = r_op_shift;
  assign fu_rs1_val_o    = r_val[0];
  assign fu_rs2_val_o    = r_val[1];

endmodule

// File: tb/tb_res_station.sv
// Directed bench for res_station (TAG = ALU_1). Each step drives inputs,
// pushes the expected post-edge outputs to a scoreboard, clocks once and
// pops/compares against the DUT.

module tb_res_station;
  import res_station_pkg::*;

  logic      clk;
  logic      reset;
  cdb_t      cdb;
  logic      write;
  alu_op_t   alu_op;
  shift_op_t sh_op;
  rs_tag_t   tag1;
  rs_tag_t   tag2;
  word32_t   value1;
  word32_t   value2;
  logic      fu_ready;
  alu_op_t   fu_alu;
  shift_op_t fu_shift;
  word32_t   rs1_val;
  word32_t   rs2_val;
  logic      busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string     name;
    logic      busy;
    logic      ready;
    word32_t   rs1;
    word32_t   rs2;
    alu_op_t   alu;
    shift_op_t sh;
  } exp_t;

  exp_t sb[$];

  res_station #(.TAG(ALU_1)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .cdb_i           (cdb),
    .write_i         (write),
    .alu_opcode_i    (alu_op),
    .shift_opcode_i  (sh_op),
    .tag1_i          (tag1),
    .tag2_i          (tag2),
    .value1_i        (value1),
    .value2_i        (value2),
    .fu_ready_o      (fu_ready),
    .fu_alu_oper_o   (fu_alu),
    .fu_shift_oper_o (fu_shift),
    .fu_rs1_val_o    (rs1_val),
    .fu_rs2_val_o    (rs2_val),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic w, input alu_op_t a, input shift_op_t s,
                       input rs_tag_t t1, input rs_tag_t t2,
                       input word32_t v1, input word32_t v2,
                       input rs_tag_t ctag, input word32_t cval);
    write      = w;
    alu_op     = a;
    sh_op      = s;
    tag1       = t1;
    tag2       = t2;
    value1     = v1;
    value2     = v2;
    cdb.tag    = ctag;
    cdb.val    = cval;
  endtask

  task automatic idle_bus();
    drive(1'b0, SUBR, SRAR, ALU_3, ALU_3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, NO_VAL, 'x);
  endtask

  task automatic expect_out(input string n, input logic b, input logic r,
                            input word32_t x1, input word32_t x2,
                            input alu_op_t a, input shift_op_t s);
    exp_t e;
    e.name = n; e.busy = b; e.ready = r; e.rs1 = x1; e.rs2 = x2; e.alu = a; e.sh = s;
    sb.push_back(e);
  endtask

  task automatic cmp(input string n, input string field,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", n, field, obs, exp);
    end
  endtask

  // Clock once, then compare the oldest scoreboard entry #1 after the edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      cmp(e.name, "busy",  {31'd0, busy},     {31'd0, e.busy});
      cmp(e.name, "ready", {31'd0, fu_ready}, {31'd0, e.ready});
      cmp(e.name, "rs1",   rs1_val,           e.rs1);
      cmp(e.name, "rs2",   rs2_val,           e.rs2);
      cmp(e.name, "alu",   {28'd0, fu_alu},   {28'd0, e.alu});
      cmp(e.name, "shift", {29'd0, fu_shift}, {29'd0, e.sh});
      $display("step %-14s busy=%0b ready=%0b rs1=%0d rs2=%0d alu=%0d sh=%0d",
               e.name, busy, fu_ready, rs1_val, rs2_val, fu_alu, fu_shift);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_bus();

    // Reset state.
    expect_out("reset", 0, 0, 0, 0, ADDI, SLLI); step();
    reset = 1'b0;

    // Ready op, foreign broadcast, idle bus carrying junk, then release.
    drive(1, ADDI, SRLI, NO_VAL, NO_VAL, 43, 7, NO_VAL, 'x);
    expect_out("ready_issue", 1, 1, 43, 7, ADDI, SRLI); step();
    drive(0, SUBR, SRAR, NO_VAL, NO_VAL, 0, 0, ALU_2, 858);
    expect_out("foreign_cdb", 1, 1, 43, 7, ADDI, SRLI); step();
    drive(0, SUBR, SRAR, NO_VAL, NO_VAL, 0, 0, NO_VAL, 123);
    expect_out("noval_cdb", 1, 1, 43, 7, ADDI, SRLI); step();
    drive(0, SUBR, SRAR, NO_VAL, NO_VAL, 0, 0, ALU_1, 50);
    expect_out("release1", 0, 0, 43, 7, ADDI, SRLI); step();
    drive(0, SUBR, SRAR, NO_VAL, NO_VAL, 0, 0, ALU_1, 77);
    expect_out("own_tag_idle", 0, 0, 43, 7, ADDI, SRLI); step();

    // One pending operand; a write while busy is ignored.
    drive(1, SUBR, SLLR, NO_VAL, ALU_2, 40, 999, NO_VAL, 'x);
    expect_out("one_pend", 1, 0, 40, 999, SUBR, SLLR); step();
    drive(1, ADDI, SLLI, NO_VAL, NO_VAL, 1, 1, ALU_3, 11);
    expect_out("write_busy", 1, 0, 40, 999, SUBR, SLLR); step();
    drive(0, ADDI, SLLI, NO_VAL, NO_VAL, 0, 0, ALU_2, 50);
    expect_out("one_fill", 1, 1, 40, 50, SUBR, SLLR); step();
    drive(0, ADDI, SLLI, NO_VAL, NO_VAL, 0, 0, ALU_1, 90);
    expect_out("release2", 0, 0, 40, 50, SUBR, SLLR); step();

    // Two pending operands from different producers.
    drive(1, ADDR, SRLR, ALU_3, ALU_2, 0, 0, NO_VAL, 'x);
    expect_out("two_pend", 1, 0, 0, 0, ADDR, SRLR); step();
    drive(0, ADDI, SLLI, NO_VAL, NO_VAL, 0, 0, ALU_3, 30);
    expect_out("two_fill1", 1, 0, 30, 0, ADDR, SRLR); step();
    drive(0, ADDI, SLLI, NO_VAL, NO_VAL, 0, 0, ALU_2, 20);
    expect_out("two_fill2", 1, 1, 30, 20, ADDR, SRLR); step();
    drive(0, ADDI, SLLI, NO_VAL, NO_VAL, 0, 0, ALU_1, 50);
    expect_out("release3", 0, 0, 30, 20, ADDR, SRLR); step();

    // Same producer feeds both operands in one broadcast.
    drive(1, ORR, SRAI, ALU_2, ALU_2, 0, 0, NO_VAL, 'x);
    expect_out("same_pend", 1, 0, 0, 0, ORR, SRAI); step();
    drive(0, ADDI, SLLI, NO_VAL, NO_VAL, 0, 0, ALU_2, 5);
    expect_out("same_fill", 1, 1, 5, 5, ORR, SRAI); step();
    drive(0, ADDI, SLLI, NO_VAL, NO_VAL, 0, 0, ALU_1, 6);
    expect_out("release4", 0, 0, 5, 5, ORR, SRAI); step();

    // Back-to-back: release and new issue in the same cycle.
    drive(1, XORR, SRLI, NO_VAL, NO_VAL, 3, 4, NO_VAL, 'x);
    expect_out("xorr_issue", 1, 1, 3, 4, XORR, SRLI); step();
    drive(1, ADDI, SLLI, NO_VAL, NO_VAL, 20, 2, ALU_1, 0);
    expect_out("b2b_ready", 1, 1, 20, 2, ADDI, SLLI); step();
    drive(1, SUBR, SRAI, NO_VAL, ALU_3, 8, 777, ALU_1, 22);
    expect_out("b2b_pend", 1, 0, 8, 777, SUBR, SRAI); step();
    drive(0, ADDI, SLLI, NO_VAL, NO_VAL, 0, 0, ALU_3, 5);
    expect_out("b2b_fill", 1, 1, 8, 5, SUBR, SRAI); step();

    // Reset while busy.
    reset = 1'b1;
    drive(0, ADDI, SLLI, NO_VAL, NO_VAL, 0, 0, ALU_1, 1);
    expect_out("reset_mid", 0, 0, 0, 0, ADDI, SLLI); step();
    reset = 1'b0;

    // Same-cycle forward at issue.
    drive(1, ANDR, SLLR, ALU_2, NO_VAL, 1234, 3, ALU_2, 9);
    expect_out("fwd_issue", 1, 1, 9, 3, ANDR, SLLR); step();
    idle_bus();
    expect_out("fwd_hold", 1, 1, 9, 3, ANDR, SLLR); step();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
